// File: rtl/fcvt_share_arb.sv
// rtl/fcvt_share_arb.sv - two-requester round-robin share of one float-to-int converter (optional FCVT_ARB_PERF_CNT_EN counters)

module ftoi (
    input  logic [31:0] x,
    input  logic        rm,
    output logic [31:0] y
);
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [4:0]  w_sh;
    logic [54:0] w_wide;
    logic [31:0] w_ip;
    logic        w_frac;

    // Integer part lands in w_wide[54:23]; anything below is the discarded fraction.
    always_comb begin
        w_sign = x[31];
        w_exp  = x[30:23];
        w_sh   = 5'(w_exp - 8'd127);
        w_wide = {31'b0, 1'b1, x[22:0]} << w_sh;
        w_ip   = w_wide[54:23];
        w_frac = |w_wide[22:0];
        if (w_exp >= 8'd158) begin
            y = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (w_exp < 8'd127) begin
            y = (w_sign & rm & (|x[30:0])) ? 32'hFFFF_FFFF : 32'h0000_0000;
        end else if (!w_sign) begin
            y = w_ip;
        end else begin
            y = -(w_ip + {31'b0, rm & w_frac});
        end
    end
endmodule

module fcvt_share_arb #(
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic             req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic             req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_y,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag
`ifdef FCVT_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      perf_cnt0,
    output logic [31:0]      perf_cnt1,
    output logic [31:0]      perf_stall
`endif
);
    logic [LAT:1]     r_v;
    logic [31:0]      r_y   [1:LAT];
    logic             r_id  [1:LAT];
    logic [TAG_W-1:0] r_tag [1:LAT];
    logic             r_rr_last;

    logic [LAT:1]     w_adv;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_acc0;
    logic             w_acc1;
    logic [31:0]      w_x;
    logic             w_rm;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_y;

    // A stage may advance if it is empty or the stage ahead of it advances.
    always_comb begin
        logic w_carry;
        w_adv      = '0;
        w_carry    = !r_v[LAT] | resp_ready;
        w_adv[LAT] = w_carry;
        for (int k = LAT - 1; k >= 1; k--) begin
            w_carry  = !r_v[k] | w_carry;
            w_adv[k] = w_carry;
        end
    end

    // r_rr_last==1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_grant0   = req0_valid & (!req1_valid | r_rr_last);
    assign w_grant1   = req1_valid & (!req0_valid | !r_rr_last);
    assign req0_ready = w_grant0 & w_adv[1];
    assign req1_ready = w_grant1 & w_adv[1];
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    assign w_x   = w_grant1 ? req1_x   : req0_x;
    assign w_rm  = w_grant1 ? req1_rm  : req0_rm;
    assign w_tag = w_grant1 ? req1_tag : req0_tag;

    ftoi u_ftoi (
        .x  (w_x),
        .rm (w_rm),
        .y  (w_y)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_last <= 1'b1;
        end else if (w_acc0) begin
            r_rr_last <= 1'b0;
        end else if (w_acc1) begin
            r_rr_last <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v <= '0;
            for (int k = 1; k <= LAT; k++) begin
                r_y[k]   <= '0;
                r_id[k]  <= 1'b0;
                r_tag[k] <= '0;
            end
        end else begin
            if (w_adv[1]) begin
                r_v[1]   <= w_acc0 | w_acc1;
                r_y[1]   <= w_y;
                r_id[1]  <= w_grant1;
                r_tag[1] <= w_tag;
            end
            for (int k = 2; k <= LAT; k++) begin
                if (w_adv[k]) begin
                    r_v[k]   <= r_v[k-1];
                    r_y[k]   <= r_y[k-1];
                    r_id[k]  <= r_id[k-1];
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end
    end

    assign resp_valid = r_v[LAT];
    assign resp_y     = r_y[LAT];
    assign resp_id    = r_id[LAT];
    assign resp_tag   = r_tag[LAT];

`ifdef FCVT_ARB_PERF_CNT_EN
    logic [31:0] r_perf_cnt0;
    logic [31:0] r_perf_cnt1;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_cnt0  <= '0;
            r_perf_cnt1  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_acc0) r_perf_cnt0 <= r_perf_cnt0 + 32'd1;
            if (w_acc1) r_perf_cnt1 <= r_perf_cnt1 + 32'd1;
            if (r_v[LAT] & !resp_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_cnt0  = r_perf_cnt0;
    assign perf_cnt1  = r_perf_cnt1;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: doc/fcvt_share_arb.md
Name: fcvt_share_arb

Overview:
- Shares one float-to-int converter (module ftoi: x[31:0], rm, y[31:0]) between two requesters, e.g. the FPU issue port and the load/convert microsequencer.
- Round-robin arbitration, valid/ready handshakes, an LAT-stage bubble-collapsing result pipeline, and one shared response port carrying requester id and tag.

Parameters:
- LAT, 2, cycles from accepted request to resp_valid; legal range 1..4.
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_x  in  32  requester 0 IEEE-754 single operand
- req0_rm  in  1  requester 0 mode: 0 truncate toward zero, 1 floor
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid / req1_ready / req1_x / req1_rm / req1_tag  same as requester 0
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_y  out  32  signed int32 result
- resp_id  out  1  requester that issued the op
- resp_tag  out  TAG_W  tag of the op

Behaviour:
- Reset (rstn low, asynchronous):
  - all stage valids = 0; resp_valid = 0; resp_y = 0; resp_id = 0; resp_tag = 0.
  - rr_last = 1, so requester 0 wins the first tie.
- Pipeline:
  - stages S1..S_LAT, each with v, y, id, tag; the output ports are driven by S_LAT.
  - The converter sits combinationally between the arbiter mux and S1.
  - y at S1 is ftoi(x, rm) of the granted request.
- Advance rule, bubble-collapsing:
  - adv[LAT] = !v[LAT] | resp_ready.
  - adv[k] = !v[k] | adv[k+1].
  - A stage loads from its predecessor when adv is set; when it loads from an empty predecessor, it clears v.
  - A stage holds all fields when !adv.
- Arbiter:
  - s1_can_load = adv[1].
  - Only one valid: grant it.
  - Both valid: grant the requester != rr_last.
  - reqN_ready = grantN & s1_can_load. It is combinational from valids and resp_ready; no combinational path from x, rm or tag.
  - Accepted handshake = reqN_valid & reqN_ready. At most one per cycle. rr_last updates to N only on an accepted handshake.
- Latency and throughput:
  - An accepted op appears on resp_* exactly LAT cycles later when no backpressure.
  - Sustained throughput is 1 op/cycle with resp_ready held high.
- Backpressure:
  - resp_valid & !resp_ready holds resp_* stable.
  - Upstream bubbles still collapse.
  - Once all LAT stages are full, both readys drop.
- Ordering: responses leave in acceptance order; no reordering.
- Requester rules:
  - A requester must hold valid, x, rm and tag stable until ready.
  - The block does not depend on this for correctness; a dropped valid simply yields no grant.
- Converter semantics, for checking:
  - exponent < 127 → 0, or 0xFFFFFFFF when negative with rm=1.
  - exponent >= 158 → 0x7FFFFFFF when positive, 0x80000000 when negative.
  - Otherwise, truncate toward zero (rm=0) or floor (rm=1).
  - A negative zero result → 0x00000000.
- Reset mid-operation: in-flight ops are discarded with no response, and the arbiter restarts at requester 0.
- Simultaneous accept and drain: when S_LAT is consumed in the same cycle an op is accepted, both happen; occupancy is unchanged.

Optional Feature:
- Macro FCVT_ARB_PERF_CNT_EN.
- Defined:
  - adds outputs perf_cnt0 [31:0] and perf_cnt1 [31:0], counting accepted handshakes per requester.
  - adds output perf_stall [31:0], counting cycles with resp_valid & !resp_ready.
  - Counters reset to 0 on rstn and wrap modulo 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single op, LAT=2: req0 x=0x40490FDB, rm=0, tag=5 → resp_valid 2 cycles after accept, y=0x00000003, id=0, tag=5.
- Rounding modes: x=0xC0490FDB with rm=0 → y=0xFFFFFFFD; rm=1 → 0xFFFFFFFC. x=0xBF000000 with rm=1 → 0xFFFFFFFF; rm=0 → 0x00000000.
- Saturation: x=0x4F000000 → 0x7FFFFFFF; x=0xCF000000 → 0x80000000.
- Fairness: both valid continuously for 8 cycles, resp_ready=1 → grants alternate 0,1,0,1…; ids alternate on output; 1 result/cycle after LAT fill.
- Backpressure: resp_ready=0 for 6 cycles with both requesters valid → exactly LAT ops accepted, then readys=0 and resp_* stable. Release → results drain in acceptance order, no loss or duplication.
- Reset mid-flight: assert rstn low with 2 ops in flight → resp_valid=0 immediately. After release, a simultaneous request from both grants requester 0 first.
